// File: rtl/z16_pkg.sv
// Shared types and constants for the Z16 data-memory arbiter.
package z16_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef enum logic {
        PORT_CPU,
        PORT_LDR
    } port_id_t;

    localparam logic [15:0] LED_ADDR_DEF = 16'h007A;

endpackage

// File: rtl/z16_rr_arb2.sv
// Two-way round-robin picker; the last-winner state is held by the parent.
module z16_rr_arb2
    import z16_pkg::*;
(
    input  logic       i_req_cpu,
    input  logic       i_req_ldr,
    input  port_id_t   i_last,
    output logic [1:0] o_gnt
);

    logic cpu_win;
    logic ldr_win;

    // On a tie the port that did not win last time takes the grant.
    always_comb begin
        cpu_win = i_req_cpu & (~i_req_ldr | (i_last == PORT_LDR));
        ldr_win = i_req_ldr & (~i_req_cpu | (i_last == PORT_CPU));
        o_gnt   = {ldr_win, cpu_win};
    end

endmodule

// File: rtl/z16_mem_arbiter.sv
// Shares the Z16 data memory between the CPU and loader ports and decodes the LED register.
module z16_mem_arbiter
    import z16_pkg::*;
#(
    parameter int unsigned             ADDR_W   = 16,
    parameter int unsigned             DATA_W   = 16,
    parameter logic [ADDR_W-1:0]       LED_ADDR = LED_ADDR_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    input  logic              i_ldr_req,
    input  logic              i_ldr_we,
    input  logic [ADDR_W-1:0] i_ldr_addr,
    input  logic [DATA_W-1:0] i_ldr_wdata,
    output logic              o_ldr_gnt,
    output logic              o_ldr_rvalid,
    output logic [DATA_W-1:0] o_ldr_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [5:0]        o_led
);

    state_t            state;
    port_id_t          last_win;
    port_id_t          lat_port;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [5:0]        led_q;
    logic [1:0]        arb_gnt;
    logic [1:0]        gnt;
    logic              lat_is_led;
    logic              resp_act;
    logic [DATA_W-1:0] rdata;

    z16_rr_arb2 u_arb (
        .i_req_cpu (i_cpu_req),
        .i_req_ldr (i_ldr_req),
        .i_last    (last_win),
        .o_gnt     (arb_gnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            last_win  <= PORT_LDR;
            lat_port  <= PORT_CPU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            led_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|arb_gnt) begin
                        lat_port  <= arb_gnt[1] ? PORT_LDR : PORT_CPU;
                        last_win  <= arb_gnt[1] ? PORT_LDR : PORT_CPU;
                        lat_we    <= arb_gnt[1] ? i_ldr_we    : i_cpu_we;
                        lat_addr  <= arb_gnt[1] ? i_ldr_addr  : i_cpu_addr;
                        lat_wdata <= arb_gnt[1] ? i_ldr_wdata : i_cpu_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lat_we) begin
                        if (lat_is_led) led_q <= lat_wdata[5:0];
                        state <= IDLE;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Grants, write strobe and rvalid are gated by reset so nothing escapes in the reset cycle.
    always_comb begin
        lat_is_led = (lat_addr == LED_ADDR);
        gnt        = arb_gnt & {2{(state == IDLE) && !i_rst}};
        resp_act   = (state == RESP) && !i_rst;
        rdata      = lat_is_led ? {{(DATA_W-6){1'b0}}, led_q} : i_mem_rdata;

        o_cpu_gnt    = gnt[0];
        o_ldr_gnt    = gnt[1];
        o_cpu_rvalid = resp_act && (lat_port == PORT_CPU);
        o_ldr_rvalid = resp_act && (lat_port == PORT_LDR);
        o_cpu_rdata  = rdata;
        o_ldr_rdata  = rdata;
        o_mem_addr   = lat_addr;
        o_mem_wdata  = lat_wdata;
        o_mem_wen    = (state == ISSUE) && lat_we && !lat_is_led && !i_rst;
        o_led        = led_q;
    end

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Directed, table-driven bench for z16_mem_arbiter with hand-computed expectations.
module tb_z16_mem_arbiter;

    logic        i_clk, i_rst;
    logic        i_cpu_req, i_cpu_we, i_ldr_req, i_ldr_we;
    logic [15:0] i_cpu_addr, i_cpu_wdata, i_ldr_addr, i_ldr_wdata, i_mem_rdata;
    logic        o_cpu_gnt, o_cpu_rvalid, o_ldr_gnt, o_ldr_rvalid, o_mem_wen;
    logic [15:0] o_cpu_rdata, o_ldr_rdata, o_mem_addr, o_mem_wdata;
    logic [5:0]  o_led;

    int n_vec = 0;
    int n_bad = 0;

    z16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LED_ADDR(16'h007A)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
        .i_cpu_wdata(i_cpu_wdata), .o_cpu_gnt(o_cpu_gnt), .o_cpu_rvalid(o_cpu_rvalid),
        .o_cpu_rdata(o_cpu_rdata),
        .i_ldr_req(i_ldr_req), .i_ldr_we(i_ldr_we), .i_ldr_addr(i_ldr_addr),
        .i_ldr_wdata(i_ldr_wdata), .o_ldr_gnt(o_ldr_gnt), .o_ldr_rvalid(o_ldr_rvalid),
        .o_ldr_rdata(o_ldr_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_led(o_led)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        c_req, c_we;
        logic [15:0] c_addr, c_wd;
        logic        l_req, l_we;
        logic [15:0] l_addr, l_wd, mrd;
        logic        e_cgnt, e_crv, e_lgnt, e_lrv, e_wen;
        logic [15:0] e_rd, e_maddr, e_mwd;
        logic [5:0]  e_led;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(input logic c_req, c_we, input logic [15:0] c_addr, c_wd,
                                input logic l_req, l_we, input logic [15:0] l_addr, l_wd, mrd,
                                input logic e_cgnt, e_crv, e_lgnt, e_lrv, e_wen,
                                input logic [15:0] e_rd, e_maddr, e_mwd, input logic [5:0] e_led);
        vec_t v;
        v.c_req = c_req;   v.c_we = c_we;   v.c_addr = c_addr; v.c_wd = c_wd;
        v.l_req = l_req;   v.l_we = l_we;   v.l_addr = l_addr; v.l_wd = l_wd;
        v.mrd = mrd;       v.e_cgnt = e_cgnt; v.e_crv = e_crv; v.e_lgnt = e_lgnt;
        v.e_lrv = e_lrv;   v.e_wen = e_wen; v.e_rd = e_rd;     v.e_maddr = e_maddr;
        v.e_mwd = e_mwd;   v.e_led = e_led;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic c_req, c_we, input logic [15:0] c_addr, c_wd,
                         input logic l_req, l_we, input logic [15:0] l_addr, l_wd, mrd);
        i_cpu_req = c_req; i_cpu_we = c_we; i_cpu_addr = c_addr; i_cpu_wdata = c_wd;
        i_ldr_req = l_req; i_ldr_we = l_we; i_ldr_addr = l_addr; i_ldr_wdata = l_wd;
        i_mem_rdata = mrd;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        // Reset state is IDLE, last winner = loader, so the bench plans the CPU to win the first tie.
        vt[0]  = mk(1,1,16'h0010,16'hBEEF, 0,0,16'h0000,16'h0000, 16'h0000, 1,0,0,0,0, 16'h0000,16'h0000,16'h0000, 6'h00);
        vt[1]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,0,0,0,1, 16'h0000,16'h0010,16'hBEEF, 6'h00);
        vt[2]  = mk(0,0,16'h0000,16'h0000, 1,0,16'h0010,16'h0000, 16'h0000, 0,0,1,0,0, 16'h0000,16'h0000,16'h0000, 6'h00);
        vt[3]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,0,0,0,0, 16'h0000,16'h0000,16'h0000, 6'h00);
        vt[4]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'hBEEF, 0,0,0,1,0, 16'hBEEF,16'h0000,16'h0000, 6'h00);
        vt[5]  = mk(1,1,16'h007A,16'h00FF, 0,0,16'h0000,16'h0000, 16'h0000, 1,0,0,0,0, 16'h0000,16'h0000,16'h0000, 6'h00);
        vt[6]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,0,0,0,0, 16'h0000,16'h0000,16'h0000, 6'h00);
        vt[7]  = mk(1,0,16'h007A,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 1,0,0,0,0, 16'h0000,16'h0000,16'h0000, 6'h3F);
        vt[8]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000, 0,0,0,0,0, 16'h0000,16'h0000,16'h0000, 6'h3F);
        vt[9]  = mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h1234, 0,1,0,0,0, 16'h003F,16'h0000,16'h0000, 6'h3F);
        vt[10] = mk(1,0,16'h0100,16'h0000, 1,0,16'h0200,16'h0000, 16'h0000, 0,0,1,0,0, 16'h0000,16'h0000,16'h0000, 6'h3F);
        vt[11] = mk(1,0,16'h0100,16'h0000, 1,0,16'h0200,16'h0000, 16'h0000, 0,0,0,0,0, 16'h0000,16'h0000,16'h0000, 6'h3F);
        vt[12] = mk(1,0,16'h0100,16'h0000, 1,0,16'h0200,16'h0000, 16'h5555, 0,0,0,1,0, 16'h5555,16'h0000,16'h0000, 6'h3F);
        vt[13] = mk(1,0,16'h0100,16'h0000, 1,0,16'h0200,16'h0000, 16'h0000, 1,0,0,0,0, 16'h0000,16'h0000,16'h0000, 6'h3F);
        vt[14] = mk(1,0,16'h0100,16'h0000, 1,0,16'h0200,16'h0000, 16'h0000, 0,0,0,0,0, 16'h0000,16'h0000,16'h0000, 6'h3F);
        vt[15] = mk(1,0,16'h0100,16'h0000, 1,0,16'h0200,16'h0000, 16'hAAAA, 0,1,0,0,0, 16'hAAAA,16'h0000,16'h0000, 6'h3F);
        vt[16] = mk(1,0,16'h0100,16'h0000, 1,0,16'h0200,16'h0000, 16'h0000, 0,0,1,0,0, 16'h0000,16'h0000,16'h0000, 6'h3F);

        // Reset with both requests high: no grant may leak while i_rst is asserted.
        i_rst = 1'b1;
        drive(1,0,16'h0001,16'h0000, 1,0,16'h0002,16'h0000, 16'h0000);
        step(); step();
        @(negedge i_clk);
        chk("rst_cgnt", {31'b0, o_cpu_gnt}, 0);
        chk("rst_lgnt", {31'b0, o_ldr_gnt}, 0);
        chk("rst_wen",  {31'b0, o_mem_wen}, 0);
        chk("rst_rv",   {30'b0, o_cpu_rvalid, o_ldr_rvalid}, 0);
        chk("rst_led",  {26'b0, o_led}, 0);
        chk("rst_maddr", {16'b0, o_mem_addr}, 0);
        drive(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000);
        step();
        i_rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].c_req, vt[i].c_we, vt[i].c_addr, vt[i].c_wd,
                  vt[i].l_req, vt[i].l_we, vt[i].l_addr, vt[i].l_wd, vt[i].mrd);
            @(negedge i_clk);
            chk($sformatf("v%0d_cgnt", i), {31'b0, o_cpu_gnt},    {31'b0, vt[i].e_cgnt});
            chk($sformatf("v%0d_lgnt", i), {31'b0, o_ldr_gnt},    {31'b0, vt[i].e_lgnt});
            chk($sformatf("v%0d_crv", i),  {31'b0, o_cpu_rvalid}, {31'b0, vt[i].e_crv});
            chk($sformatf("v%0d_lrv", i),  {31'b0, o_ldr_rvalid}, {31'b0, vt[i].e_lrv});
            chk($sformatf("v%0d_wen", i),  {31'b0, o_mem_wen},    {31'b0, vt[i].e_wen});
            chk($sformatf("v%0d_led", i),  {26'b0, o_led},        {26'b0, vt[i].e_led});
            if (vt[i].e_crv) chk($sformatf("v%0d_crd", i), {16'b0, o_cpu_rdata}, {16'b0, vt[i].e_rd});
            if (vt[i].e_lrv) chk($sformatf("v%0d_lrd", i), {16'b0, o_ldr_rdata}, {16'b0, vt[i].e_rd});
            if (vt[i].e_wen) begin
                chk($sformatf("v%0d_maddr", i), {16'b0, o_mem_addr},  {16'b0, vt[i].e_maddr});
                chk($sformatf("v%0d_mwd", i),   {16'b0, o_mem_wdata}, {16'b0, vt[i].e_mwd});
            end
            step();
        end

        // Drain the loader read left in flight by the last vector.
        drive(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000);
        step(); step(); step();

        // Reset asserted in the ISSUE cycle of a CPU write to 0x0020.
        drive(1,1,16'h0020,16'h1111, 0,0,16'h0000,16'h0000, 16'h0000);
        @(negedge i_clk);
        chk("rw_gnt", {31'b0, o_cpu_gnt}, 1);
        step();
        i_rst = 1'b1;
        drive(1,0,16'h0030,16'h0000, 1,0,16'h0040,16'h0000, 16'h0000);
        @(negedge i_clk);
        chk("rw_wen",  {31'b0, o_mem_wen}, 0);
        chk("rw_gnts", {30'b0, o_ldr_gnt, o_cpu_gnt}, 0);
        step();
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rw_led",  {26'b0, o_led}, 0);
        chk("rw_tie",  {30'b0, o_ldr_gnt, o_cpu_gnt}, 2'b01);
        chk("rw_wen2", {31'b0, o_mem_wen}, 0);
        drive(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000);
        step(); step(); step();

        // CPU raises then drops its request while the loader read is in progress.
        drive(0,0,16'h0000,16'h0000, 1,0,16'h0300,16'h0000, 16'h0000);
        @(negedge i_clk);
        chk("dr_lgnt", {31'b0, o_ldr_gnt}, 1);
        step();
        drive(1,0,16'h0400,16'h0000, 0,0,16'h0000,16'h0000, 16'h0000);
        @(negedge i_clk);
        chk("dr_cgnt_issue", {31'b0, o_cpu_gnt}, 0);
        step();
        drive(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 16'h7777);
        @(negedge i_clk);
        chk("dr_lrv",  {31'b0, o_ldr_rvalid}, 1);
        chk("dr_lrd",  {16'b0, o_ldr_rdata}, 16'h7777);
        chk("dr_crv",  {31'b0, o_cpu_rvalid}, 0);
        step();
        @(negedge i_clk);
        chk("dr_cgnt_idle", {31'b0, o_cpu_gnt}, 0);
        step();
        @(negedge i_clk);
        chk("dr_cgnt_idle2", {31'b0, o_cpu_gnt}, 0);
        chk("dr_wen", {31'b0, o_mem_wen}, 0);

        // Both ports reading continuously from reset: CPU at 0,6; loader at 3,9.
        i_rst = 1'b1;
        drive(1,0,16'h0500,16'h0000, 1,0,16'h0600,16'h0000, 16'h4242);
        step(); step();
        i_rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge i_clk);
            chk($sformatf("rr%0d_cgnt", c), {31'b0, o_cpu_gnt},    {31'b0, (c % 6) == 0});
            chk($sformatf("rr%0d_lgnt", c), {31'b0, o_ldr_gnt},    {31'b0, (c % 6) == 3});
            chk($sformatf("rr%0d_crv", c),  {31'b0, o_cpu_rvalid}, {31'b0, (c % 6) == 2});
            chk($sformatf("rr%0d_lrv", c),  {31'b0, o_ldr_rvalid}, {31'b0, (c % 6) == 5});
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/z16_mem_arbiter.md
# z16_mem_arbiter

Two-port arbiter that shares the single Z16 data memory between the CPU load/store port and a program/data loader port (UART or debug). It grants one request at a time with round-robin fairness and sequences each access through a fixed issue/response pipeline. It also decodes the LED MMIO address so that both requesters can reach the LED register. It sits between the CPU core, the loader and the data memory macro, which has a synchronous read: data is valid one cycle after the address.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- LED_ADDR, 16'h007A, MMIO address of the LED register

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_cpu_req  in  1  CPU access request; held until o_cpu_gnt
- i_cpu_we  in  1  1 = write, 0 = read
- i_cpu_addr  in  ADDR_W  byte address
- i_cpu_wdata  in  DATA_W  write data
- o_cpu_gnt  out  1  one-cycle pulse; request accepted
- o_cpu_rvalid  out  1  one-cycle pulse; o_cpu_rdata valid
- o_cpu_rdata  out  DATA_W  read data
- i_ldr_req, i_ldr_we, i_ldr_addr, i_ldr_wdata, o_ldr_gnt, o_ldr_rvalid, o_ldr_rdata: loader port, same directions, widths and meanings as the CPU port
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wen  out  1  memory write enable
- o_mem_wdata  out  DATA_W  memory write data
- i_mem_rdata  in  DATA_W  memory read data, valid the cycle after the address
- o_led  out  6  LED register

## Operation
- FSM states are IDLE, ISSUE and RESP.
- IDLE:
  - If any request is present, pulse gnt to the winner, latch its we/addr/wdata and its port ID, then go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - Drive o_mem_addr from the latched address.
  - Latched write to an address other than LED_ADDR: assert o_mem_wen and drive o_mem_wdata.
  - Latched write to LED_ADDR: o_mem_wen stays 0 and o_led <= wdata[5:0].
  - After a write, go to IDLE. After a read, go to RESP.
- RESP:
  - Assert rvalid on the latched port only.
  - rdata = i_mem_rdata, or {10'b0, o_led} when the latched address is LED_ADDR.
  - Go to IDLE.
- Arbitration:
  - A 1-bit last-winner register is updated on every grant.
  - When both ports request, the port that did not win last gets the grant.
  - After reset, last-winner = loader, so the CPU wins the first tie.
  - A single requester always wins.
- Fairness: a continuously requesting port completes at most one access before a waiting port is granted.
- o_mem_wen is 0 in every state except ISSUE with a non-LED write.
- The o_mem_addr and o_mem_wdata values outside ISSUE are don't-care, but are held at the latched values to avoid glitches.
- A requester that drops req before its gnt pulse is legal; it simply loses its turn.
- Reset values: state = IDLE, last-winner = loader, o_led = 0, all gnt/rvalid/o_mem_wen = 0, latched registers = 0.
- Reset mid-operation: the access is abandoned, no rvalid is issued, and no memory or LED write occurs in the reset cycle.

## Timing
- Grant in cycle N (IDLE), memory access in N+1 (ISSUE), rvalid in N+2 (RESP).
- Write: 2 cycles per access, next grant possible at N+2.
- Read: 3 cycles per access, next grant possible at N+3.
- A LED read uses the same N+2 latency as a memory read.
- gnt is combinational from the state and the request inputs; it is asserted only in IDLE.
- rvalid and rdata are combinational in RESP, and rdata is held stable for that one cycle.
- A request arriving in ISSUE or RESP is not granted until the next IDLE cycle; it is never dropped while req stays high.

## Structure
- Shared package z16_pkg:
  - state enum {IDLE, ISSUE, RESP}
  - port ID enum {PORT_CPU, PORT_LDR}
  - LED_ADDR default constant
- Sub-module z16_rr_arb2: 2-way round-robin picker.
  - Inputs: two requests, last-winner.
  - Outputs: one-hot grant.
  - Purely combinational; the last-winner register lives in the parent.

## Test plan
- CPU write addr 0x0010 data 0xBEEF alone:
  - o_cpu_gnt at N.
  - o_mem_wen=1, o_mem_addr=0x0010, o_mem_wdata=0xBEEF at N+1.
  - No rvalid.
- Loader read 0x0010 with memory returning 0xBEEF: o_ldr_rvalid=1, o_ldr_rdata=0xBEEF at N+2; o_cpu_rvalid stays 0.
- Both ports request reads continuously from reset:
  - Grants alternate CPU, LDR, CPU, LDR at cycles 0, 3, 6, 9.
- CPU write LED_ADDR data 0x00FF:
  - o_mem_wen=0 throughout; o_led=6'h3F from N+2.
  - Follow-up read of LED_ADDR returns 0x003F.
- i_rst asserted in the ISSUE cycle of a write to 0x0020:
  - o_mem_wen=0 and state IDLE after reset; no gnt while i_rst=1.
  - o_led=0; the next tie grants the CPU.
- CPU drops req before gnt while the loader is mid-access: the loader completes normally and no CPU grant follows.
